// File: rtl/sistema_y_comparator.sv
// Registered 4-bit unsigned magnitude comparator with a Q rising-edge pulse.
// A is assembled from the individual bits {a,b,c,d}; B is sampled every cycle.
module sistema_y_comparator (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   input  logic [3:0] B,
   output logic       Q,
   output logic       eq,
   output logic       lt,
   output logic       q_rise
);

   logic [3:0] val_a;
   logic       gt_next;
   logic       eq_next;
   logic       lt_next;
   logic       q_prev;

   assign val_a = {a, b, c, d};

   // MSB-first magnitude cascade: the first differing bit decides the order.
   always_comb begin
      gt_next = 1'b0;
      lt_next = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (!gt_next && !lt_next) begin
            if (val_a[i] && !B[i])
               gt_next = 1'b1;
            else if (!val_a[i] && B[i])
               lt_next = 1'b1;
         end
      end
      eq_next = !gt_next && !lt_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Q      <= 1'b0;
         eq     <= 1'b0;
         lt     <= 1'b0;
         q_prev <= 1'b0;
      end else begin
         Q      <= gt_next;
         eq     <= eq_next;
         lt     <= lt_next;
         q_prev <= Q;
      end
   end

   // Pulse is high alongside the first cycle of a registered Q = 1.
   assign q_rise = Q & ~q_prev;

endmodule

// File: tb/tb_sistema_y_comparator.sv
// Directed and random checks for sistema_y_comparator.
// Outputs are packed {Q,eq,lt,q_rise} and sampled 1 ns after each rising edge.
module tb_sistema_y_comparator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a, b, c, d;
   logic [3:0] B;
   logic       Q, eq, lt, q_rise;

   integer n_checks = 0;
   integer n_errors = 0;
   logic   prev_q;

   sistema_y_comparator dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .c      (c),
      .d      (d),
      .B      (B),
      .Q      (Q),
      .eq     (eq),
      .lt     (lt),
      .q_rise (q_rise)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic drive(input logic [3:0] av, input logic [3:0] bv);
      @(negedge clk);
      {a, b, c, d} = av;
      B = bv;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] outs();
      return {Q, eq, lt, q_rise};
   endfunction

   initial begin
      logic [3:0] ra, rb;
      logic       gt, e, l;

      rst_n = 1'b0;
      {a, b, c, d} = 4'd0;
      B = 4'd0;
      #23;
      check("reset_hold", outs(), 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Sweep against B = 3 after a priming cycle with Q = 0.
      drive(4'd0, 4'd3);
      check("prime_b3", outs(), 4'b0010);
      for (int i = 0; i < 16; i++) begin
         drive(4'(i), 4'd3);
         check($sformatf("b3_a%0d", i), outs(),
               (i < 3) ? 4'b0010 : (i == 3) ? 4'b0100 : (i == 4) ? 4'b1001 : 4'b1000);
      end

      for (int i = 0; i < 16; i++) begin
         drive(4'(i), 4'd15);
         check($sformatf("b15_a%0d", i), outs(), (i == 15) ? 4'b0100 : 4'b0010);
      end

      for (int i = 0; i < 16; i++) begin
         drive(4'(i), 4'd0);
         check($sformatf("b0_a%0d", i), outs(),
               (i == 0) ? 4'b0100 : (i == 1) ? 4'b1001 : 4'b1000);
      end

      // A held at 10 while B steps down through it.
      drive(4'd10, 4'd10);
      check("bchg_eq", outs(), 4'b0100);
      drive(4'd10, 4'd9);
      check("bchg_rise", outs(), 4'b1001);
      drive(4'd10, 4'd9);
      check("bchg_hold", outs(), 4'b1000);

      // Simultaneous A/B change compared as a pair.
      drive(4'd5, 4'd6);
      check("pair_lt", outs(), 4'b0010);
      drive(4'd7, 4'd6);
      check("pair_gt", outs(), 4'b1001);

      // Mid-cycle asynchronous reset.
      drive(4'd12, 4'd3);
      check("pre_rst", outs(), 4'b1000);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", outs(), 4'b0000);
      @(negedge clk);
      check("rst_low_edge", outs(), 4'b0000);
      rst_n = 1'b1;
      #1;
      check("rst_release", outs(), 4'b0000);
      @(posedge clk);
      #1;
      check("post_rst_rise", outs(), 4'b1001);
      drive(4'd12, 4'd3);
      check("post_rst_hold", outs(), 4'b1000);

      // Random pairs against a reference model.
      prev_q = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         drive(ra, rb);
         gt = (ra > rb);
         e  = (ra == rb);
         l  = (ra < rb);
         check("rand", outs(), {gt, e, l, gt & ~prev_q});
         check("onehot", 4'($countones({Q, eq, lt})), 4'd1);
         prev_q = gt;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
